// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding fetch at a time, holds the returned
// instruction for decode and advances the PC sequentially or by an aligned redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misaligned_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            count_q    <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        count_d    = count_q;
        fault_d    = fault_q;
        case (state_q)
            StIdle: state_d = StReq;
            // Responses seen here belong to an abandoned request and are dropped.
            StReq: begin
                if (imem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (imem_resp_valid) begin
                    instr_d    = imem_resp_data;
                    instr_pc_d = pc_q;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                    state_d = StReq;
                    if (!redirect_valid) begin
                        pc_d = pc_q + 32'd4;
                    end else if (redirect_target[1:0] != 2'b00) begin
                        // PC is left untouched; the unit stays parked until reset.
                        state_d = StFault;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_target;
                    end
                end
            end
            StFault: fault_d = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    assign imem_req_valid   = (state_q == StReq);
    assign imem_req_addr    = pc_q;
    assign instr_valid      = (state_q == StHold);
    assign instr            = instr_valid ? instr_q : NOP_INSTR;
    assign instr_pc         = instr_pc_q;
    assign misaligned_fault = fault_q;
    assign fetch_count      = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset values, sequential fetch, decode stall,
// redirects (aligned and misaligned), PC and counter wrap, reset mid-transaction.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        misaligned_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misaligned_fault(misaligned_fault),
        .fetch_count     (fetch_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One zero-wait transaction starting in REQ, ending one cycle after the consume.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input logic rdir, input logic [31:0] tgt);
        check("req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_instr", instr, data);
        check("hold_pc", instr_pc, addr);
        instr_ready     = 1'b1;
        redirect_valid  = rdir;
        redirect_target = tgt;
        step();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fault", {31'b0, misaligned_fault}, 32'd0);
        check("rst_count", fetch_count, 32'h0);

        reset = 1'b0;
        check("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
        step();

        fetch(32'h0, 32'h0050_0093, 1'b0, 32'h0);
        check("first_count", fetch_count, 32'd1);
        check("first_next_addr", imem_req_addr, 32'h4);

        // Memory not ready, plus a stale response in REQ that must be ignored.
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0BAD;
        step();
        step();
        imem_resp_valid = 1'b0;
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("stall_req_addr", imem_req_addr, 32'h4);
        check("stale_dropped", {31'b0, instr_valid}, 32'd0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_8133;
        step();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hs_instr", instr, 32'h0020_8133);
            check("hs_pc", instr_pc, 32'h4);
            check("hs_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("hs_next_addr", imem_req_addr, 32'h8);
        check("hs_count", fetch_count, 32'd2);

        fetch(32'h8, 32'h0000_0113, 1'b0, 32'h0);
        fetch(32'hC, 32'h0000_0193, 1'b0, 32'h0);

        // Redirect pulsed in WAIT is ignored; consume-cycle redirect is taken.
        check("r_addr", imem_req_addr, 32'h10);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("r_wait_addr", imem_req_addr, 32'h10);
        check("r_wait_no_valid", {31'b0, instr_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1000_006F;
        step();
        imem_resp_valid = 1'b0;
        check("r_instr_pc", instr_pc, 32'h10);
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        check("r_target", imem_req_addr, 32'h100);
        check("r_count", fetch_count, 32'd5);

        fetch(32'h100, 32'h0000_0067, 1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0);
        check("pc_wrap", imem_req_addr, 32'h0);
        check("count_7", fetch_count, 32'd7);

        dut.count_q = 32'hFFFF_FFFF;
        fetch(32'h0, 32'h0050_0093, 1'b0, 32'h0);
        check("count_wrap", fetch_count, 32'h0);

        fetch(32'h4, 32'h0020_006F, 1'b1, 32'h102);
        check("fault_set", {31'b0, misaligned_fault}, 32'd1);
        check("fault_count", fetch_count, 32'd1);
        check("fault_pc_kept", imem_req_addr, 32'h4);
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        instr_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fault_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("fault_no_valid", {31'b0, instr_valid}, 32'd0);
            check("fault_nop", instr, NOP);
            check("fault_sticky", {31'b0, misaligned_fault}, 32'd1);
        end
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        instr_ready     = 1'b0;

        reset = 1'b1;
        #1;
        check("rf_fault_clr", {31'b0, misaligned_fault}, 32'd0);
        check("rf_count_clr", fetch_count, 32'h0);
        check("rf_addr", imem_req_addr, 32'h0);
        step();
        reset = 1'b0;
        step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        // Now in WAIT: reset abandons it; a late response must be dropped.
        reset = 1'b1;
        step();
        reset           = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        check("late_dropped", {31'b0, instr_valid}, 32'd0);
        check("late_nop", instr, NOP);
        check("fresh_req", {31'b0, imem_req_valid}, 32'd1);
        check("fresh_addr", imem_req_addr, 32'h0);
        step();
        imem_resp_valid = 1'b0;
        check("late_still_req", {31'b0, imem_req_valid}, 32'd1);
        check("late_still_no_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'h0, 32'h0010_0113, 1'b0, 32'h0);
        check("restart_count", fetch_count, 32'd1);
        check("restart_next", imem_req_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
